// File: rtl/nrisc_trace_buffer.sv
// Circular execution-trace capture for the nRisc core: armed capture, PC/forced trigger,
// programmable post-trigger window, indexed readout. Optional timestamps via TRACE_TIMESTAMP_EN.
module nrisc_trace_buffer #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 8,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int TS_W    = 16,
   localparam int AW     = $clog2(DEPTH),
`ifdef TRACE_TIMESTAMP_EN
   localparam bit TS_EN  = 1'b1,
`else
   localparam bit TS_EN  = 1'b0,
`endif
   localparam int ENTRY_W = (TS_EN ? TS_W : 0) + PC_W + INSTR_W + DATA_W
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               arm,
   input  logic               force_trig,
   input  logic               cap_valid,
   input  logic [PC_W-1:0]    cap_pc,
   input  logic [INSTR_W-1:0] cap_instr,
   input  logic [DATA_W-1:0]  cap_data,
   input  logic               trig_en,
   input  logic [PC_W-1:0]    trig_pc,
   input  logic [AW-1:0]      post_cnt,
   input  logic               rd_req,
   input  logic [AW-1:0]      rd_idx,
   output logic               rd_valid,
   output logic [ENTRY_W-1:0] rd_entry,
   output logic [AW:0]        count,
   output logic [1:0]         state,
   output logic               triggered
);

   typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11} state_e;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   state_e             state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic               trig_q, trig_d;
   logic [AW-1:0]      post_q, post_d;
   logic [AW-1:0]      remain_q, remain_d;
   logic               rd_valid_q, rd_valid_d;
   logic [ENTRY_W-1:0] rd_entry_q, rd_entry_d;
   logic               wr_en;
   logic [ENTRY_W-1:0] wr_data;
   logic [AW-1:0]      oldest, rd_addr;
   logic [ENTRY_W-1:0] mem [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) ts_q <= '0;
      else        ts_q <= ts_q + 1'b1;
   end
   assign wr_data = {ts_q, cap_pc, cap_instr, cap_data};
`else
   assign wr_data = {cap_pc, cap_instr, cap_data};
`endif

   // Once the buffer has filled, the oldest entry sits where the next write would land.
   assign oldest  = count_q[AW] ? wr_ptr_q : '0;
   assign rd_addr = oldest + rd_idx;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      trig_d     = trig_q;
      post_d     = post_q;
      remain_d   = remain_q;
      rd_valid_d = 1'b0;
      rd_entry_d = rd_entry_q;
      wr_en      = 1'b0;
      if (arm) begin
         state_d  = ARMED;
         wr_ptr_d = '0;
         count_d  = '0;
         trig_d   = 1'b0;
         post_d   = post_cnt;
         remain_d = '0;
      end else begin
         case (state_q)
            ARMED: begin
               wr_en = cap_valid;
               if ((cap_valid && trig_en && cap_pc == trig_pc) || force_trig) begin
                  trig_d   = 1'b1;
                  remain_d = post_q;
                  state_d  = (post_q == '0) ? DONE : POST;
               end
            end
            POST: begin
               if (cap_valid) begin
                  wr_en    = 1'b1;
                  remain_d = remain_q - 1'b1;
                  if (remain_q == AW'(1)) state_d = DONE;
               end
            end
            DONE: begin
               if (rd_req) begin
                  rd_valid_d = 1'b1;
                  rd_entry_d = ({1'b0, rd_idx} < count_q) ? mem[rd_addr] : '0;
               end
            end
            default: ;
         endcase
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != FULL) count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         trig_q     <= 1'b0;
         post_q     <= '0;
         remain_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_entry_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         trig_q     <= trig_d;
         post_q     <= post_d;
         remain_q   <= remain_d;
         rd_valid_q <= rd_valid_d;
         rd_entry_q <= rd_entry_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_valid  = rd_valid_q;
   assign rd_entry  = rd_entry_q;
   assign count     = count_q;
   assign state     = state_q;
   assign triggered = trig_q;

endmodule
